adder_32_bit: RTL and testbench

// - Registered 32-bit two-operand adder for the MIPS datapath, used for PC+4 and address increments.
// - Sums op1 and op2 combinationally through a carry-lookahead network.
// - Captures the sum into an output register on the rising clock edge when enabled.
// - Driven by the shared free-running clock module (instance name sys_clock); not part of this block.
//

---
 rtl/adder_32_bit_pkg.sv | 10 +
 rtl/adder_32_bit_cla_4_bit.sv | 30 +++
 rtl/adder_32_bit.sv | 83 ++++++++
 tb/tb_adder_32_bit.sv | 124 ++++++++++++
 4 files changed

// File: rtl/adder_32_bit_pkg.sv
// Shared datapath constants for the registered adder.
package adder_32_bit_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] RESET_VAL = 32'h0000_0000;

    // Carry-lookahead group size; WIDTH must be a multiple of this.
    localparam int unsigned CLA_GROUP = 4;

endpackage

// File: rtl/adder_32_bit_cla_4_bit.sv
// 4-bit carry-lookahead slice: sum plus group propagate/generate.
module adder_32_bit_cla_4_bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] s_o,
    output logic       p_o,
    output logic       g_o
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    // Group P/G depend only on the operands, never on cin, so the
    // second-level lookahead in the top can consume them without a loop.
    assign p_o = &p;
    assign g_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & cin_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);

    assign s_o = p ^ c;

endmodule

// File: rtl/adder_32_bit.sv
// Registered two-operand adder built from a two-level carry-lookahead network.
module adder_32_bit
    import adder_32_bit_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_WIDTH
) (
    input  logic             clk,
    input  logic             en,
    input  logic             reset,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic [WIDTH-1:0] out
);

    localparam int unsigned NumGroups = WIDTH / CLA_GROUP;

    if ((WIDTH % CLA_GROUP) != 0) begin : g_bad_width
        $error("adder_32_bit: WIDTH must be a multiple of 4");
    end

    logic [NumGroups-1:0] grp_p;
    logic [NumGroups-1:0] grp_g;
    logic [NumGroups:0]   grp_c;
    logic [WIDTH-1:0]     sum;
    logic [WIDTH-1:0]     out_d;
    logic [WIDTH-1:0]     out_q;
    logic                 la_term;
    logic                 la_acc;
    logic                 unused_cout;

    for (genvar gi = 0; gi < NumGroups; gi++) begin : g_cla
        adder_32_bit_cla_4_bit u_cla (
            .a_i   (op1[gi*4 +: 4]),
            .b_i   (op2[gi*4 +: 4]),
            .cin_i (grp_c[gi]),
            .s_o   (sum[gi*4 +: 4]),
            .p_o   (grp_p[gi]),
            .g_o   (grp_g[gi])
        );
    end

    // Second-level lookahead: each group carry is a flat sum-of-products of
    // lower group P/G terms (adder carry-in is 0), so no ripple between groups.
    always_comb begin
        grp_c    = '0;
        la_term  = 1'b0;
        la_acc   = 1'b0;
        for (int i = 0; i < int'(NumGroups); i++) begin
            la_acc = 1'b0;
            for (int j = 0; j <= i; j++) begin
                la_term = grp_g[j];
                for (int k = j + 1; k <= i; k++) begin
                    la_term = la_term & grp_p[k];
                end
                la_acc = la_acc | la_term;
            end
            grp_c[i+1] = la_acc;
        end
    end

    // Carry-out of the MSB is discarded: the sum wraps mod 2^WIDTH.
    assign unused_cout = grp_c[NumGroups];

    // Enable mux: load the new sum or hold the current value.
    always_comb begin
        out_d = out_q;
        if (en) begin
            out_d = sum;
        end
    end

    // Output register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= WIDTH'(RESET_VAL);
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_adder_32_bit.sv
// Self-checking bench for adder_32_bit against a behavioural register model.
module tb_adder_32_bit;

    logic        clk;
    logic        en;
    logic        reset;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] out;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Behavioural model of the registered sum.
    logic [31:0] model_q;

    adder_32_bit #(
        .WIDTH (32)
    ) dut (
        .clk   (clk),
        .en    (en),
        .reset (reset),
        .op1   (op1),
        .op2   (op2),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, step the model at the
    // rising edge and compare shortly after it.
    task automatic cycle(input string tag, input logic e, input logic [31:0] a,
                         input logic [31:0] b);
        logic [32:0] wide;
        @(negedge clk);
        en  = e;
        op1 = a;
        op2 = b;
        @(posedge clk);
        #1;
        if (reset === 1'b1 && e) begin
            wide    = {1'b0, a} + {1'b0, b};
            model_q = wide[31:0];
        end
        check_eq(tag, out, model_q);
    endtask

    initial begin
        logic        r_en;
        logic [31:0] r_a;
        logic [31:0] r_b;

        reset   = 1'b0;
        en      = 1'b1;
        op1     = 32'h0;
        op2     = 32'h4;
        model_q = 32'h0;

        // Reset held low: loads are ignored.
        for (int i = 0; i < 3; i++) begin
            cycle("reset_hold", 1'b1, 32'h0, 32'h4);
        end

        @(negedge clk);
        reset = 1'b1;

        // Basic increment sequence.
        for (int i = 0; i <= 48; i += 4) begin
            cycle("basic_add", 1'b1, 32'(i), 32'h4);
        end

        // Reset between edges clears at once; no load while held.
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_q = 32'h0;
        check_eq("async_reset", out, model_q);
        cycle("reset_mid_hold", 1'b1, 32'h1234, 32'h1);
        @(negedge clk);
        reset = 1'b1;

        // Enable hold.
        cycle("en_load", 1'b1, 32'h10, 32'h4);
        cycle("en_hold", 1'b0, 32'h100, 32'h4);
        cycle("en_hold2", 1'b0, 32'h200, 32'h4);
        cycle("en_reload", 1'b1, 32'h100, 32'h4);

        // Operand changes between edges do not affect the register.
        @(negedge clk);
        op1 = 32'hdead_beef;
        #1;
        check_eq("between_edges", out, model_q);

        // Wrap and carry-chain corners.
        cycle("wrap_ones", 1'b1, 32'hffff_ffff, 32'h1);
        cycle("wrap_msb", 1'b1, 32'h8000_0000, 32'h8000_0000);
        cycle("carry_16", 1'b1, 32'h0000_ffff, 32'h1);
        cycle("carry_28", 1'b1, 32'h0fff_ffff, 32'h1);
        cycle("carry_grp", 1'b1, 32'h0000_000f, 32'h1);
        cycle("carry_alt", 1'b1, 32'h7777_7777, 32'h8888_8889);

        // Random operands with randomly toggled enable.
        for (int i = 0; i < 1000; i++) begin
            r_en = 1'($urandom_range(0, 1));
            r_a  = $urandom;
            r_b  = $urandom;
            cycle("random", r_en, r_a, r_b);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
